// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and constants
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH_RUN   = 2'd0,
    FETCH_STALL = 2'd1,
    FETCH_FLUSH = 2'd2,
    FETCH_RSVD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with hold and flush
module ifid_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] instr_d,
  input  logic [31:0] pcplus4_d,
  output logic [31:0] instr,
  output logic [31:0] pcplus4,
  output logic        valid
);

  // Flush beats hold; a flushed entry keeps its PC+4 so only the bubble marker changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr   <= NOP_INSTR;
      pcplus4 <= 32'h0;
      valid   <= 1'b0;
    end else if (flush) begin
      instr   <= NOP_INSTR;
      valid   <= 1'b0;
    end else if (!hold) begin
      instr   <= instr_d;
      pcplus4 <= pcplus4_d;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, fetch FSM and IF/ID loading
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Stall,
  input  logic                 Redirect,
  input  logic [31:0]          RedirectTarget,
  output logic [31:0]          IMemAddr,
  input  logic [31:0]          IMemData,
  output logic [31:0]          IFID_Instr,
  output logic [31:0]          IFID_PCPlus4,
  output logic                 IFID_Valid,
  output logic [1:0]           FetchState,
  output logic                 Misaligned,
  output logic [CNT_WIDTH-1:0] FetchCount,
  output logic [CNT_WIDTH-1:0] StallCount
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  fetch_state_t state;

  assign pc_plus4   = pc + 32'd4;
  assign IMemAddr   = pc;
  assign FetchState = state;

  // Every branch names its next state explicitly, so the unused encoding
  // falls back into the normal flow on the following edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc         <= RESET_PC;
      state      <= FETCH_RUN;
      Misaligned <= 1'b0;
      FetchCount <= '0;
      StallCount <= '0;
    end else if (Redirect) begin
      pc    <= align_word(RedirectTarget);
      state <= FETCH_FLUSH;
      if (|RedirectTarget[1:0]) Misaligned <= 1'b1;
    end else if (Stall) begin
      state <= FETCH_STALL;
      if (StallCount != CNT_MAX) StallCount <= StallCount + CNT_ONE;
    end else begin
      pc    <= pc_plus4;
      state <= FETCH_RUN;
      if (FetchCount != CNT_MAX) FetchCount <= FetchCount + CNT_ONE;
    end
  end

  ifid_reg u_ifid (
    .clk       (Clk),
    .reset     (Reset),
    .hold      (Stall),
    .flush     (Redirect),
    .instr_d   (IMemData),
    .pcplus4_d (pc_plus4),
    .instr     (IFID_Instr),
    .pcplus4   (IFID_PCPlus4),
    .valid     (IFID_Valid)
  );

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage of the pipelined MIPS datapath: owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register. It sits directly downstream of the 1-bit branch/jump OR that produces the single redirect request, and applies that request together with the hazard unit's stall. Keeps saturating fetch/stall counters for lab performance reporting.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
- CNT_WIDTH, 32, width of performance counters

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  one clock; reset is synchronous and active-high
- Stall  in  1  hazard unit: hold PC and IF/ID
- Redirect  in  1  branch-taken OR jump (output of the 1-bit OR)
- RedirectTarget  in  32  new PC when Redirect=1
- IMemAddr  out  32  instruction memory address (= PC, combinational)
- IMemData  in  32  instruction word read asynchronously at IMemAddr
- IFID_Instr  out  32  registered instruction to decode
- IFID_PCPlus4  out  32  registered PC+4 of that instruction
- IFID_Valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble
- FetchState  out  2  current FSM state encoding
- Misaligned  out  1  sticky: a redirect target had bits[1:0] != 0
- FetchCount  out  CNT_WIDTH  valid instructions loaded into IF/ID
- StallCount  out  CNT_WIDTH  cycles spent in STALL

## Operation
- Reset values: PC=RESET_PC, IFID_Instr=32'h0 (nop), IFID_PCPlus4=0, IFID_Valid=0, FetchState=RUN, Misaligned=0, both counters 0.
- Priority per edge: Reset > Redirect > Stall > normal fetch.
- Normal (RUN, no Stall/Redirect): PC<=PC+4 (mod 2^32, wraps 32'hFFFF_FFFC→0); IFID_Instr<=IMemData; IFID_PCPlus4<=PC+4; IFID_Valid<=1; FetchCount++.
- Stall (no Redirect): PC and all IF/ID fields hold; state→STALL; StallCount++.
- Redirect (regardless of Stall): PC<={RedirectTarget[31:2],2'b00}; IF/ID flushed (Instr=0, Valid=0, PCPlus4 unchanged); state→FLUSH; if RedirectTarget[1:0]!=0 set Misaligned (cleared only by Reset).
- FSM states: RUN=2'd0, STALL=2'd1, FLUSH=2'd2; 2'd3 unused, recovers to RUN next edge.
  - RUN: Redirect→FLUSH; Stall→STALL; else RUN.
  - STALL: Redirect→FLUSH; Stall→STALL; else RUN (fetch performed this edge).
  - FLUSH: lasts exactly one cycle of bubble at IF/ID output; next edge behaves as RUN transition rules (Redirect→FLUSH again, Stall→STALL, else RUN with fetch from target).
- Counters saturate at all-ones; no wrap.
- Reset asserted mid-stall or same edge as Redirect: reset values win entirely.

## Timing
- IMemAddr is combinational from PC; IMemData assumed valid same cycle.
- Fetch latency: instruction at PC visible on IFID_* one edge after PC is presented.
- Redirect penalty: exactly one bubble cycle (IFID_Valid=0) before target instruction appears; target instruction valid on second edge after Redirect sampled.
- Stall of N cycles holds IF/ID for N cycles; fetch resumes on edge where Stall=0.
- Redirect and Stall are sampled only at rising Clk; single-cycle pulses are sufficient.

## Structure
- Shared package (mips_pkg): FETCH_RUN/FETCH_STALL/FETCH_FLUSH state constants, NOP_INSTR=32'h0, RESET_PC default.
- One natural sub-module: ifid_reg (IF/ID pipeline register with hold and flush inputs); PC register, next-PC mux, FSM and counters in pc_fetch_unit top.

## Test plan
- Reset then 4 free-running cycles, IMem returns 32'h1000_0000+addr → IFID_PCPlus4 = 4,8,12,16; FetchCount=4; IFID_Valid=1 from first edge after Reset drops.
- Stall high 3 cycles at PC=0x8 → PC and IF/ID hold, FetchState=STALL, StallCount=3, fetch resumes at 0x8 next edge.
- Redirect=1, target 0x40 at PC=0x10 → next edge IFID_Valid=0, PC=0x40, FetchState=FLUSH; following edge IFID_PCPlus4=0x44, Valid=1.
- Redirect and Stall together, target 0x80 → redirect wins: PC=0x80, bubble, StallCount unchanged.
- Redirect target 0x43 → PC=0x40, Misaligned=1 and stays 1 until Reset; Reset asserted during a stall → all outputs return to reset values next edge.
- RESET_PC=32'hFFFF_FFFC, one fetch → PC wraps to 0, IFID_PCPlus4=0.
